// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parameterised synchronous FIFO.
package fifo_pkg;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_DEPTH     = 4;
    localparam int DEF_AF_THRESH = DEF_DEPTH - 1;
    localparam int DEF_AE_THRESH = 1;

    // Occupancy spans 0..DEPTH inclusive, hence DEPTH+1 distinct values.
    function automatic int count_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                      CLK,
    input  logic                      i_we,
    input  logic [ptr_w(DEPTH)-1:0]   i_waddr,
    input  logic [WIDTH-1:0]          i_wdata,
    input  logic [ptr_w(DEPTH)-1:0]   i_raddr,
    output logic [WIDTH-1:0]          o_rdata
);

    // Storage is deliberately left unreset; occupancy is tracked by the pointers.
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Synchronous first-word-fall-through FIFO with threshold flags and sticky error flags.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AF_THRESH = DEPTH - 1,
    parameter int AE_THRESH = DEF_AE_THRESH
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        flush,
    input  logic                        write_en,
    input  logic [WIDTH-1:0]            write_data,
    output logic                        write_rdy,
    input  logic                        read_en,
    output logic [WIDTH-1:0]            read_data,
    output logic                        read_rdy,
    output logic [count_w(DEPTH)-1:0]   count,
    output logic                        almost_full,
    output logic                        almost_empty,
    output logic                        err_ovf,
    output logic                        err_udf
);

    localparam int CW = count_w(DEPTH);
    localparam int PW = ptr_w(DEPTH);

    if (DEPTH < 2) begin : g_bad_depth
        $error("sync_fifo_param: DEPTH must be at least 2");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
        $error("sync_fifo_param: AF_THRESH must lie in 1..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH >= DEPTH) begin : g_bad_ae
        $error("sync_fifo_param: AE_THRESH must lie in 0..DEPTH-1");
    end

    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_err_ovf;
    logic          r_err_udf;

    logic          w_full;
    logic          w_empty;
    logic          w_wr;
    logic          w_rd;
    logic          w_mem_we;
    logic [PW-1:0] w_wptr_nxt;
    logic [PW-1:0] w_rptr_nxt;

    // Handshake: a write transfers on a rising edge when write_en && write_rdy,
    // a read when read_en && read_rdy; both ready flags come from registered
    // count only, so neither depends on the requests in the same cycle.
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_wr    = write_en && !w_full;
    assign w_rd    = read_en && !w_empty;

    // Explicit wrap keeps non-power-of-two depths correct.
    assign w_wptr_nxt = (r_wptr == PW'(DEPTH - 1)) ? '0 : r_wptr + PW'(1);
    assign w_rptr_nxt = (r_rptr == PW'(DEPTH - 1)) ? '0 : r_rptr + PW'(1);

    assign w_mem_we = w_wr && !RST && !flush;

    always_ff @(posedge CLK) begin
        if (RST || flush) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_err_ovf <= 1'b0;
            r_err_udf <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wptr <= w_wptr_nxt;
            end
            if (w_rd) begin
                r_rptr <= w_rptr_nxt;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (write_en && w_full) begin
                r_err_ovf <= 1'b1;
            end
            if (read_en && w_empty) begin
                r_err_udf <= 1'b1;
            end
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .CLK     (CLK),
        .i_we    (w_mem_we),
        .i_waddr (r_wptr),
        .i_wdata (write_data),
        .i_raddr (r_rptr),
        .o_rdata (read_data)
    );

    assign write_rdy    = !w_full;
    assign read_rdy     = !w_empty;
    assign count        = r_count;
    assign almost_full  = (r_count >= CW'(AF_THRESH));
    assign almost_empty = (r_count <= CW'(AE_THRESH));
    assign err_ovf      = r_err_ovf;
    assign err_udf      = r_err_udf;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param: a depth-4 and a depth-5 instance share stimulus.
module tb_sync_fifo_param;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       flush = 1'b0;
    logic       write_en = 1'b0;
    logic [7:0] write_data = '0;
    logic       read_en = 1'b0;

    logic       a_write_rdy, a_read_rdy, a_af, a_ae, a_ovf, a_udf;
    logic [7:0] a_read_data;
    logic [2:0] a_count;
    logic       b_write_rdy, b_read_rdy, b_af, b_ae, b_ovf, b_udf;
    logic [7:0] b_read_data;
    logic [2:0] b_count;

    always #5 CLK = ~CLK;

    sync_fifo_param #(.WIDTH(8), .DEPTH(4), .AF_THRESH(3), .AE_THRESH(1)) u_dut_a (
        .CLK(CLK), .RST(RST), .flush(flush),
        .write_en(write_en), .write_data(write_data), .write_rdy(a_write_rdy),
        .read_en(read_en), .read_data(a_read_data), .read_rdy(a_read_rdy),
        .count(a_count), .almost_full(a_af), .almost_empty(a_ae),
        .err_ovf(a_ovf), .err_udf(a_udf)
    );

    sync_fifo_param #(.WIDTH(8), .DEPTH(5), .AF_THRESH(4), .AE_THRESH(1)) u_dut_b (
        .CLK(CLK), .RST(RST), .flush(flush),
        .write_en(write_en), .write_data(write_data), .write_rdy(b_write_rdy),
        .read_en(read_en), .read_data(b_read_data), .read_rdy(b_read_rdy),
        .count(b_count), .almost_full(b_af), .almost_empty(b_ae),
        .err_ovf(b_ovf), .err_udf(b_udf)
    );

    // Selected-instance view of the outputs.
    logic       sel = 1'b0;
    logic       s_write_rdy, s_read_rdy, s_af, s_ae, s_ovf, s_udf;
    logic [7:0] s_read_data;
    logic [2:0] s_count;
    assign s_write_rdy = sel ? b_write_rdy : a_write_rdy;
    assign s_read_rdy  = sel ? b_read_rdy  : a_read_rdy;
    assign s_af        = sel ? b_af        : a_af;
    assign s_ae        = sel ? b_ae        : a_ae;
    assign s_ovf       = sel ? b_ovf       : a_ovf;
    assign s_udf       = sel ? b_udf       : a_udf;
    assign s_read_data = sel ? b_read_data : a_read_data;
    assign s_count     = sel ? b_count     : a_count;

    // Scoreboard and reference state.
    logic [7:0] exp_q[$];
    int         m_depth = 4;
    int         m_af_th = 3;
    bit         m_ovf = 1'b0;
    bit         m_udf = 1'b0;
    int         n_vec = 0;
    int         n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle of stimulus, followed by reference update and output checks.
    task automatic step(input bit rst, input bit fl, input bit we, input logic [7:0] wd,
                        input bit re);
        bit wa;
        bit ra;
        wa = we && (exp_q.size() != m_depth);
        ra = re && (exp_q.size() != 0);
        if (!rst && !fl && ra) begin
            check("rd_head", {56'd0, s_read_data}, {56'd0, exp_q[0]});
        end
        RST = rst; flush = fl; write_en = we; write_data = wd; read_en = re;
        @(posedge CLK);
        #1;
        RST = 1'b0; flush = 1'b0; write_en = 1'b0; read_en = 1'b0;
        if (rst || fl) begin
            exp_q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            if (we && !wa) m_ovf = 1'b1;
            if (re && !ra) m_udf = 1'b1;
            if (ra) void'(exp_q.pop_front());
            if (wa) exp_q.push_back(wd);
        end
        check("count",     64'(s_count),     64'(exp_q.size()));
        check("write_rdy", 64'(s_write_rdy), 64'(exp_q.size() != m_depth));
        check("read_rdy",  64'(s_read_rdy),  64'(exp_q.size() != 0));
        check("almost_full",  64'(s_af),     64'(exp_q.size() >= m_af_th));
        check("almost_empty", 64'(s_ae),     64'(exp_q.size() <= 1));
        check("err_ovf",   64'(s_ovf),       64'(m_ovf));
        check("err_udf",   64'(s_udf),       64'(m_udf));
        check("count_max", 64'(s_count <= 3'(m_depth)), 64'd1);
        if (exp_q.size() != 0) begin
            check("rd_data", {56'd0, s_read_data}, {56'd0, exp_q[0]});
        end
    endtask

    initial begin
        int nw;
        int nr;
        int iter;
        bit we;
        bit re;
        logic [7:0] d;

        // Reset held two cycles, then one idle cycle.
        repeat (2) step(1, 0, 0, 8'h00, 0);
        step(0, 0, 0, 8'h00, 0);

        // Fill to full, overflow attempt, drain in order.
        step(0, 0, 1, 8'h11, 0);
        step(0, 0, 1, 8'h22, 0);
        step(0, 0, 1, 8'h33, 0);
        step(0, 0, 1, 8'h44, 0);
        step(0, 0, 1, 8'h55, 0);
        repeat (4) step(0, 0, 0, 8'h00, 1);
        step(0, 0, 0, 8'h00, 0);

        // Steady simultaneous traffic at count 2; pointers wrap repeatedly.
        step(1, 0, 0, 8'h00, 0);
        step(0, 0, 1, 8'hA0, 0);
        step(0, 0, 1, 8'hA1, 0);
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 1, 8'hB0 + 8'(i), 1);
        end

        // Empty edge: read with write while empty.
        repeat (2) step(0, 0, 0, 8'h00, 1);
        step(1, 0, 0, 8'h00, 0);
        step(0, 0, 1, 8'hC7, 1);
        step(0, 0, 0, 8'h00, 0);

        // Full edge: write with read while full.
        step(0, 0, 1, 8'hC8, 0);
        step(0, 0, 1, 8'hC9, 0);
        step(0, 0, 1, 8'hCA, 0);
        step(0, 0, 1, 8'hCB, 1);

        // Flush with a concurrent write at count 3.
        step(0, 0, 0, 8'h00, 0);
        step(0, 1, 1, 8'hDD, 0);
        step(0, 0, 0, 8'h00, 0);

        // Reset mid-operation with requests asserted.
        step(0, 0, 1, 8'hE1, 0);
        step(0, 0, 1, 8'hE2, 0);
        step(1, 0, 1, 8'hE3, 1);
        step(0, 0, 1, 8'hE4, 0);
        step(0, 0, 0, 8'h00, 1);

        // Depth-5 instance: random interleave of 12 writes and 12 reads.
        sel = 1'b1;
        m_depth = 5;
        m_af_th = 4;
        step(1, 0, 0, 8'h00, 0);
        nw = 0;
        nr = 0;
        iter = 0;
        while ((nw < 12 || nr < 12) && iter < 500) begin
            we = (nw < 12) && ($urandom_range(0, 1) == 1);
            re = (nr < 12) && ($urandom_range(0, 1) == 1);
            d  = 8'($urandom_range(0, 255));
            if (we && exp_q.size() != m_depth) nw++;
            if (re && exp_q.size() != 0) nr++;
            step(0, 0, we, d, re);
            iter++;
        end
        check("b_traffic_done", 64'(nw == 12 && nr == 12), 64'd1);
        check("b_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sync_fifo_param.md
SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data bits per entry, range 1..64.
REQ-002 SHALL have parameter DEPTH, default 4: number of entries, range 2..256, not necessarily a power of two.
REQ-003 SHALL have parameter AF_THRESH, default DEPTH-1: almost_full asserts when count >= AF_THRESH, range 1..DEPTH.
REQ-004 SHALL have parameter AE_THRESH, default 1: almost_empty asserts when count <= AE_THRESH, range 0..DEPTH-1.
REQ-005 SHALL have port CLK, input, 1 bit: the single clock, with all state updated on the rising edge.
REQ-006 SHALL have port RST, input, 1 bit: synchronous active-high reset.
REQ-007 SHALL have port flush, input, 1 bit: synchronous clear of the FIFO contents.
REQ-008 SHALL have port write_en, input, 1 bit: write request.
REQ-009 SHALL have port write_data, input, WIDTH bits: write payload.
REQ-010 SHALL have port write_rdy, output, 1 bit: the FIFO is not full.
REQ-011 SHALL have port read_en, input, 1 bit: read (pop) request.
REQ-012 SHALL have port read_data, output, WIDTH bits: head entry, first-word-fall-through.
REQ-013 SHALL have port read_rdy, output, 1 bit: the FIFO is not empty.
REQ-014 SHALL have port count, output, $clog2(DEPTH+1) bits: number of occupied entries.
REQ-015 SHALL have port almost_full, output, 1 bit: threshold flag.
REQ-016 SHALL have port almost_empty, output, 1 bit: threshold flag.
REQ-017 SHALL have port err_ovf, output, 1 bit: sticky flag, set by a write attempt while full.
REQ-018 SHALL have port err_udf, output, 1 bit: sticky flag, set by a read attempt while empty.

Function
REQ-019 SHALL accept a write only when write_en && write_rdy, storing write_data at wptr and advancing wptr.
REQ-020 SHALL accept a read only when read_en && read_rdy, advancing rptr.
REQ-021 SHALL drive read_data combinationally from mem[rptr] (FWFT); read_data is valid whenever read_rdy=1 and is not checked while read_rdy=0.
REQ-022 SHALL wrap wptr and rptr from DEPTH-1 to 0 with explicit compare, not natural binary overflow.
REQ-023 SHALL update count by +1 on write-only, -1 on read-only, and leave it unchanged on simultaneous accepted write and read or on no activity.
REQ-024 SHALL, when full, accept a simultaneous read and reject the write (no bypass): count becomes DEPTH-1, err_ovf is set.
REQ-025 SHALL, when empty, accept a simultaneous write and reject the read (read_rdy=0): count becomes 1, err_udf is set, and the data appears on read_data the next cycle.
REQ-026 SHALL make write-to-read latency one cycle: data written at edge N is visible with read_rdy=1 after edge N.
REQ-027 SHALL derive write_rdy = (count != DEPTH), read_rdy = (count != 0), almost_full and almost_empty from the registered count, so that no output depends combinationally on write_en or read_en.
REQ-028 SHALL keep err_ovf and err_udf at 1 once set, until RST or flush.
REQ-029 SHALL give flush priority over write and read in the same cycle: pointers, count and error flags clear, the write is discarded, and memory contents are left unchanged.
REQ-030 SHALL preserve FIFO ordering across any number of pointer wraps.

Reset
REQ-031 SHALL, with RST=1 sampled at a rising edge, set wptr=0, rptr=0 and count=0, giving write_rdy=1, read_rdy=0, almost_empty=1, almost_full=0, err_ovf=0 and err_udf=0.
REQ-032 SHALL give RST priority over flush, write and read; reset mid-operation discards all entries and ignores inputs during that cycle.
REQ-033 SHALL NOT reset the memory array.

Structure
REQ-034 SHALL place in the shared package fifo_pkg: the count-width function (clog2 of DEPTH+1) and the default WIDTH, DEPTH and threshold constants.
REQ-035 SHALL isolate storage in sub-module fifo_mem (a DEPTH x WIDTH register array with one synchronous write port and one asynchronous read port); pointer, count, flag and error logic stays in sync_fifo_param.
REQ-036 SHALL reject illegal parameters (DEPTH<2, AF_THRESH outside 1..DEPTH, AE_THRESH >= DEPTH) at elaboration.

Verification (WIDTH=8, DEPTH=4, AF_THRESH=3, AE_THRESH=1 unless stated)
REQ-037 SHALL cover reset: RST held 2 cycles then released -> count=0, write_rdy=1, read_rdy=0, almost_empty=1, almost_full=0, errors=0.
REQ-038 SHALL cover fill and drain: write 0x11, 0x22, 0x33, 0x44 -> almost_full=1 at count=3, write_rdy=0 at count=4; a fifth write 0x55 -> err_ovf=1 and count stays 4; reading 4 entries -> 0x11, 0x22, 0x33, 0x44 in order, then read_rdy=0.
REQ-039 SHALL cover simultaneous access: at count=2, write and read together for 10 cycles -> count stays 2, output order is preserved, and pointers wrap at least twice.
REQ-040 SHALL cover empty and full edges: read_en with write_en on empty -> count=1, err_udf=1, written data on read_data the next cycle; write and read together on full -> count=3, err_ovf=1.
REQ-041 SHALL cover flush: flush=1 with write_en=1 at count=3 -> next cycle count=0, read_rdy=0, err flags=0, and the write is discarded.
REQ-042 SHALL cover a non-power-of-two depth: DEPTH=5, with 12 writes and 12 reads interleaved randomly -> scoreboard match, count never exceeds 5.
